// File: rtl/async_up_counter_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : async_up_counter_ctrl_if
//  Description : Control/status bundle for the modulo-N up counter.
//                Control inputs to the counter use i_*, counter results use o_*.
//  Ports       : i_start, i_stop, i_mode, i_en, i_load, i_load_val[WIDTH]
//                o_q[WIDTH], o_tc, o_wrap, o_done, o_busy
//  Modports    : master - drives control, observes status (controller / bench)
//                slave  - the counter itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface async_up_counter_ctrl_if #(
   parameter int WIDTH = 4
);
   logic             i_start;
   logic             i_stop;
   logic             i_mode;
   logic             i_en;
   logic             i_load;
   logic [WIDTH-1:0] i_load_val;
   logic [WIDTH-1:0] o_q;
   logic             o_tc;
   logic             o_wrap;
   logic             o_done;
   logic             o_busy;

   modport master (
      output i_start, i_stop, i_mode, i_en, i_load, i_load_val,
      input  o_q, o_tc, o_wrap, o_done, o_busy
   );

   modport slave (
      input  i_start, i_stop, i_mode, i_en, i_load, i_load_val,
      output o_q, o_tc, o_wrap, o_done, o_busy
   );
endinterface
`default_nettype wire

// File: rtl/async_up_counter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : async_up_counter_ctrl
//  Description : Modulo-MOD up counter with start/stop control, parallel load
//                (clamped to 0 when out of range), free-run mode with a
//                one-cycle wrap pulse and one-shot mode that halts in DONE.
//  Ports       : clk    - system clock, rising edge
//                rst_n  - asynchronous active-low reset
//                bus    - async_up_counter_ctrl_if.slave
//                         (start/stop/mode/en/load/load_val in,
//                          q/tc/wrap/done/busy out)
//  Parameters  : WIDTH - counter width, MOD - modulus (2..2**WIDTH)
//  Revision    : 1.0 - initial release
// ============================================================================
module async_up_counter_ctrl #(
   parameter int WIDTH = 4,
   parameter int MOD   = 10
) (
   input  wire                          clk,
   input  wire                          rst_n,
   async_up_counter_ctrl_if.slave       bus
);

   // Reject an unusable modulus at elaboration time.
   if ((MOD < 2) || (MOD > (2 ** WIDTH))) begin : g_mod_check
      $error("async_up_counter_ctrl: MOD out of range for WIDTH");
   end

   localparam logic [WIDTH-1:0] C_TOP = WIDTH'(MOD - 1);
   // One extra bit so MOD == 2**WIDTH is representable for the clamp compare.
   localparam logic [WIDTH:0]   C_MOD = (WIDTH + 1)'(MOD);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_COUNT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_q;
   logic             r_mode;
   logic             r_wrap;
   logic             r_done;
   logic             r_busy;

   logic [WIDTH-1:0] w_load_q;
   logic             w_at_top;

   // Out-of-range load values collapse to 0 so q never leaves 0..MOD-1.
   assign w_load_q = ({1'b0, bus.i_load_val} >= C_MOD) ? '0 : bus.i_load_val;
   assign w_at_top = (r_q == C_TOP);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_q     <= '0;
         r_mode  <= 1'b0;
         r_wrap  <= 1'b0;
         r_done  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         // wrap is a single-cycle pulse; only the wrap branch re-asserts it.
         r_wrap <= 1'b0;

         if (bus.i_stop) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
         end else if (bus.i_start) begin
            // From IDLE the count resumes from the current q; a start while
            // already counting or halted is a restart from zero.
            if (r_state != S_IDLE) begin
               r_q <= '0;
            end
            r_mode  <= bus.i_mode;
            r_state <= S_COUNT;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
         end else if (bus.i_load) begin
            r_q <= w_load_q;
            if (r_state == S_DONE) begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
            end
         end else if ((r_state == S_COUNT) && bus.i_en) begin
            if (!w_at_top) begin
               r_q <= r_q + 1'b1;
            end else if (r_mode) begin
               // One-shot: park at MOD-1 and report completion.
               r_state <= S_DONE;
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
            end else begin
               r_q    <= '0;
               r_wrap <= 1'b1;
            end
         end
      end
   end

   assign bus.o_q    = r_q;
   assign bus.o_tc   = w_at_top;
   assign bus.o_wrap = r_wrap;
   assign bus.o_done = r_done;
   assign bus.o_busy = r_busy;

endmodule
`default_nettype wire

// File: doc/async_up_counter_ctrl.md
Name: async_up_counter_ctrl

Overview:
- Modulo-N up counter with asynchronous active-low reset, start/stop control, and parallel load.
- Two modes: free-run (wrap with pulse) or one-shot (halt at terminal count with `done`).
- Up-counting companion to the team's down counter; used as an event/interval counter in timing blocks.
- Single clock domain. All state is flopped on `clk` rising edge, except reset.

Parameters:
- WIDTH, 4, counter width in bits.
- MOD, 10, count modulus; q runs 0..MOD-1. Legal range 2 <= MOD <= 2**WIDTH; elaboration error otherwise.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- start  input  1  begin counting; latches mode.
- stop  input  1  abort to IDLE; q holds.
- mode  input  1  0 = free-run, 1 = one-shot; sampled only on an accepted start.
- en  input  1  count enable (increment qualifier).
- load  input  1  parallel load request.
- load_val  input  WIDTH  load value.
- q  output  WIDTH  current count.
- tc  output  1  terminal count, combinational: q == MOD-1.
- wrap  output  1  registered 1-cycle pulse in the cycle q shows 0 after a free-run wrap.
- done  output  1  high while in DONE.
- busy  output  1  high while in COUNT.

Behaviour:
- Reset (rst=0, any time, independent of clk):
  - q=0, state=IDLE, mode_r=0, wrap=0, done=0, busy=0.
  - Release is the synchronous deassert by the driver; the first active edge follows.
- States IDLE, COUNT, DONE. Per-edge priority within every state: stop > start > load > increment.
- IDLE:
  - q holds.
  - start: mode_r<=mode, next state COUNT; q unchanged on that edge.
  - load: q<=load_val, stays IDLE.
- COUNT:
  - en=1 and q<MOD-1: q<=q+1.
  - en=1 and q==MOD-1, mode_r=0: q<=0, wrap<=1 for one cycle, stays COUNT.
  - en=1 and q==MOD-1, mode_r=1: q holds MOD-1, next state DONE.
  - en=0: q holds.
  - load: q<=load_val, stays COUNT; no increment that edge.
  - start while in COUNT: q<=0, mode_r<=mode (restart).
- DONE:
  - done=1, q holds MOD-1, en ignored.
  - start: q<=0, mode_r<=mode, next state COUNT.
  - load: q<=load_val, next state IDLE.
- stop in any state: next state IDLE, q holds, wrap<=0.
- Load clamp: load_val >= MOD loads 0. This applies in every state.
- tc is purely combinational from q. It is asserted in any state (including IDLE after a load of MOD-1).
- wrap is deasserted on every edge where a wrap does not occur. It is never asserted in one-shot mode.
- mode changes while in COUNT have no effect until the next accepted start.
- Arithmetic: increment is modulo MOD, never modulo 2**WIDTH. q never holds a value >= MOD.
- Reset asserted mid-count, or in DONE, returns all outputs to reset values immediately, without waiting for a clk edge.

Test Plan (WIDTH=4, MOD=10):
- Free-run: rst pulse low then high; start=1 for one cycle, mode=0, en=1, 25 cycles → q runs 0,1..9,0,1..; wrap high exactly in the cycles q=0 after 9 (2 pulses); tc high when q=9; busy=1.
- One-shot: start, mode=1, en=1 → q counts 0..9 then holds 9; done=1 and busy=0 from the next edge; wrap never asserts. Then start → q=0, COUNT.
- Load/clamp: in IDLE, load_val=7 → q=7; load_val=12 → q=0. In COUNT, load_val=8 with en=1 → q=8 on that edge, 9 on the next, then 0 with a wrap pulse.
- Enable gating and stop: in COUNT at q=4, hold en=0 for 3 cycles → q stays 4. Then stop=1 together with load=1 → IDLE, q=4 (stop wins).
- Async reset mid-operation: at q=6, drop rst between clk edges → q=0, busy=0, done=0 before the next edge. After release, the counter stays IDLE until start.
- Mode change mid-count: start with mode=0; at q=3, set mode=1 → still wraps 9→0 with a wrap pulse, and DONE is never entered.
